// File: rtl/logic_unit_pipe.sv
// Registered WIDTH-bit bitwise logic unit with a 2-entry output buffer and delivered-result counter.
// Optional reduction outputs are compiled in with `define LOGIC_UNIT_PIPE_REDUCE_EN.
`timescale 1ns/1ps

module logic_unit_pipe #(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned COUNT_W = 8
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_valid,
    output logic               o_ready,
    input  logic [WIDTH-1:0]   i_a,
    input  logic [WIDTH-1:0]   i_b,
    input  logic [2:0]         i_op,
    output logic               o_valid,
    input  logic               i_ready,
    output logic [WIDTH-1:0]   o_result,
`ifdef LOGIC_UNIT_PIPE_REDUCE_EN
    output logic               o_red_and,
    output logic               o_red_or,
    output logic               o_red_xor,
`endif
    output logic [COUNT_W-1:0] o_count
);

`ifdef LOGIC_UNIT_PIPE_REDUCE_EN
    localparam int unsigned EntryW = WIDTH + 3;
`else
    localparam int unsigned EntryW = WIDTH;
`endif

    logic [WIDTH-1:0]   result_d;
    logic [EntryW-1:0]  entry_d;
    logic [EntryW-1:0]  head_q;
    logic [EntryW-1:0]  tail_q;
    logic [1:0]         occ_q;
    logic [COUNT_W-1:0] count_q;
    logic               push;
    logic               pop;

    always_comb begin
        result_d = '0;
        unique case (i_op)
            3'd0: result_d = i_a & i_b;
            3'd1: result_d = i_a | i_b;
            3'd2: result_d = ~(i_a & i_b);
            3'd3: result_d = ~(i_a | i_b);
            3'd4: result_d = i_a ^ i_b;
            3'd5: result_d = ~(i_a ^ i_b);
            3'd6: result_d = ~i_a;
            3'd7: result_d = i_a;
            default: result_d = '0;
        endcase
    end

`ifdef LOGIC_UNIT_PIPE_REDUCE_EN
    assign entry_d = {^result_d, |result_d, &result_d, result_d};
`else
    assign entry_d = result_d;
`endif

    // Handshakes depend only on registered occupancy, so o_ready never sees i_ready.
    assign o_valid = (occ_q != 2'd0);
    assign o_ready = (occ_q != 2'd2);
    assign push    = i_valid && o_ready;
    assign pop     = o_valid && i_ready;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            occ_q   <= 2'd0;
            count_q <= '0;
        end else begin
            if (pop) begin
                count_q <= count_q + COUNT_W'(1);
            end
            unique case (occ_q)
                2'd0: begin
                    if (push) begin
                        head_q <= entry_d;
                        occ_q  <= 2'd1;
                    end
                end
                2'd1: begin
                    if (push && pop) begin
                        head_q <= entry_d;
                    end else if (push) begin
                        tail_q <= entry_d;
                        occ_q  <= 2'd2;
                    end else if (pop) begin
                        occ_q  <= 2'd0;
                    end
                end
                2'd2: begin
                    if (pop) begin
                        head_q <= tail_q;
                        occ_q  <= 2'd1;
                    end
                end
                default: occ_q <= 2'd0;
            endcase
        end
    end

    assign o_result = head_q[WIDTH-1:0];
    assign o_count  = count_q;

`ifdef LOGIC_UNIT_PIPE_REDUCE_EN
    assign o_red_and = head_q[WIDTH];
    assign o_red_or  = head_q[WIDTH+1];
    assign o_red_xor = head_q[WIDTH+2];
`endif

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Scoreboard bench for logic_unit_pipe: directed steps, expected results queued on accept.
`timescale 1ns/1ps

module tb_logic_unit_pipe;

    logic       clk;
    logic       rst;
    logic       i_valid;
    logic       o_ready;
    logic [7:0] i_a;
    logic [7:0] i_b;
    logic [2:0] i_op;
    logic       o_valid;
    logic       i_ready;
    logic [7:0] o_result;
    logic [3:0] o_count;
`ifdef LOGIC_UNIT_PIPE_REDUCE_EN
    logic       o_red_and;
    logic       o_red_or;
    logic       o_red_xor;
`endif

    int checks = 0;
    int errors = 0;

    logic [7:0] exp_q[$];
    int         m_occ;
    logic [3:0] m_count;

    logic_unit_pipe #(
        .WIDTH   (8),
        .COUNT_W (4)
    ) dut (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_valid   (i_valid),
        .o_ready   (o_ready),
        .i_a       (i_a),
        .i_b       (i_b),
        .i_op      (i_op),
        .o_valid   (o_valid),
        .i_ready   (i_ready),
        .o_result  (o_result),
`ifdef LOGIC_UNIT_PIPE_REDUCE_EN
        .o_red_and (o_red_and),
        .o_red_or  (o_red_or),
        .o_red_xor (o_red_xor),
`endif
        .o_count   (o_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] ref_op(input logic [7:0] a, input logic [7:0] b,
                                          input logic [2:0] op);
        case (op)
            3'd0: return a & b;
            3'd1: return a | b;
            3'd2: return ~(a & b);
            3'd3: return ~(a | b);
            3'd4: return a ^ b;
            3'd5: return ~(a ^ b);
            3'd6: return ~a;
            default: return a;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One cycle: drive inputs, check handshake state and head vs. model, clock, update model.
    task automatic step(input logic v, input logic [7:0] a, input logic [7:0] b,
                        input logic [2:0] op, input logic r);
        logic push;
        logic pop;
        i_valid = v;
        i_a     = a;
        i_b     = b;
        i_op    = op;
        i_ready = r;
        #1;
        check("o_valid", 32'(o_valid), 32'(m_occ != 0));
        check("o_ready", 32'(o_ready), 32'(m_occ != 2));
        push = v && (m_occ != 2);
        pop  = r && (m_occ != 0);
        if (pop) begin
            if (exp_q.size() == 0) begin
                check("scoreboard_underflow", 32'(exp_q.size()), 32'd1);
            end else begin
                check("o_result", 32'(o_result), 32'(exp_q[0]));
                void'(exp_q.pop_front());
            end
        end
        if (push) exp_q.push_back(ref_op(a, b, op));
        @(posedge clk);
        #1;
        m_occ = m_occ + int'(push) - int'(pop);
        if (pop) m_count = m_count + 4'd1;
        check("o_count", 32'(o_count), 32'(m_count));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        exp_q.delete();
        m_occ   = 0;
        m_count = 4'd0;
        check("rst_o_valid", 32'(o_valid), 32'd0);
        check("rst_o_ready", 32'(o_ready), 32'd1);
        check("rst_o_count", 32'(o_count), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        rst     = 1'b1;
        i_valid = 1'b0;
        i_a     = 8'h00;
        i_b     = 8'h00;
        i_op    = 3'd0;
        i_ready = 1'b0;
        exp_q.delete();
        m_occ   = 0;
        m_count = 4'd0;
        #1;
        check("reset_o_valid", 32'(o_valid), 32'd0);
        check("reset_o_ready", 32'(o_ready), 32'd1);
        check("reset_o_result", 32'(o_result), 32'd0);
        check("reset_o_count", 32'(o_count), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // All ops, one per cycle with consumer always ready.
        for (int op = 0; op < 8; op++) step(1'b1, 8'hF0, 8'hCC, 3'(op), 1'b1);
        step(1'b0, 8'h00, 8'h00, 3'd0, 1'b1);
        check("allops_drained", 32'(exp_q.size()), 32'd0);

        // Backpressure: third pair must be refused.
        step(1'b1, 8'h5A, 8'h0F, 3'd4, 1'b0);
        step(1'b1, 8'hA5, 8'h3C, 3'd1, 1'b0);
        step(1'b1, 8'h77, 8'h11, 3'd0, 1'b0);
        check("bp_queued", 32'(exp_q.size()), 32'd2);
        step(1'b0, 8'h00, 8'h00, 3'd0, 1'b1);
        step(1'b0, 8'h00, 8'h00, 3'd0, 1'b1);
        step(1'b0, 8'h00, 8'h00, 3'd0, 1'b1);

        // Simultaneous push and pop at occupancy 1.
        step(1'b1, 8'h12, 8'h34, 3'd1, 1'b0);
        step(1'b1, 8'h0F, 8'hFF, 3'd6, 1'b1);
        check("pp_o_result", 32'(o_result), 32'hF0);
        check("pp_o_valid", 32'(o_valid), 32'd1);
        step(1'b0, 8'h00, 8'h00, 3'd0, 1'b1);

`ifdef LOGIC_UNIT_PIPE_REDUCE_EN
        step(1'b1, 8'hFF, 8'h01, 3'd4, 1'b0);
        check("red_result", 32'(o_result), 32'hFE);
        check("red_and", 32'(o_red_and), 32'd0);
        check("red_or", 32'(o_red_or), 32'd1);
        check("red_xor", 32'(o_red_xor), 32'd1);
        step(1'b0, 8'h00, 8'h00, 3'd0, 1'b1);
`endif

        // Reset mid-stream with two entries buffered.
        step(1'b1, 8'hAA, 8'h55, 3'd0, 1'b0);
        step(1'b1, 8'hAA, 8'h55, 3'd1, 1'b0);
        check("mid_full_o_ready", 32'(o_ready), 32'd0);
        do_reset();

        // Counter wrap: 17 deliveries on a 4-bit counter.
        for (int n = 0; n < 17; n++) step(1'b1, 8'(n * 7), 8'(n * 13), 3'(n), 1'b1);
        step(1'b0, 8'h00, 8'h00, 3'd0, 1'b1);
        check("wrap_o_count", 32'(o_count), 32'd1);
        check("wrap_o_valid", 32'(o_valid), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
